cic_comp_fir: RTL and testbench
===============================

# cic_comp_fir

Time-multiplexed symmetric FIR that compensates the passband droop of the CIC decimator. It sits directly downstream of the CIC decimator and consumes its `dout`/`vld` sample stream at the decimated rate. It then applies runtime-loadable coefficients using a single multiply-accumulate unit, and rounds and narrows the result. The output is presented on a valid/ready handshake toward the next DSP stage.

## Interface
- `WIDTH_IN`, default 36: input sample width, signed; matches the CIC decimator output width.
- `WIDTH_COEF`, default 18: coefficient width, signed.
- `NUM_TAPS`, default 15: filter length; must be odd and ≥3, otherwise `$error` at elaboration.
- `WIDTH_OUT`, default 16: output width, signed.
- `SHIFT`, default `WIDTH_COEF-2+WIDTH_IN-WIDTH_OUT` (36): arithmetic right shift applied to the accumulator.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  `WIDTH_IN`  input sample, signed.
- `din_vld`  in  1  input sample strobe (driven by CIC `vld`).
- `in_rdy`  out  1  block can accept a sample this cycle.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  `$clog2(K)`  coefficient index, where K = (NUM_TAPS+1)/2.
- `coef_data`  in  `WIDTH_COEF`  coefficient value, signed.
- `dout`  out  `WIDTH_OUT`  filtered sample, signed.
- `dout_vld`  out  1  `dout` valid.
- `dout_rdy`  in  1  downstream accepts `dout`.
- `ovf`  out  1  sticky flag: an input sample was dropped.

## Operation
- **Delay line:** `x[0..NUM_TAPS-1]`, with `x[0]` the newest sample. On accept (`din_vld & in_rdy`), the line shifts and `x[0] <= din`.
- **Coefficient banks:** two banks of K coefficients each, `shadow` and `active`.
  - `coef_we` writes `shadow[coef_addr]` in any state.
  - The whole `shadow` bank is copied into `active` on every accept.
  - Both banks reset to an impulse: `coef[K-1] = 2^(WIDTH_COEF-2)`, all other entries 0.
  - Writes with `coef_addr ≥ K` are ignored.
- **FSM states:** IDLE, MAC, OUT.
  - IDLE: `in_rdy=1`. On accept, clear the accumulator, set k=0, and go to MAC.
  - MAC: runs one step per cycle for k=0..K-1.
    - For k<K-1: `acc += active[k]*(x[k]+x[NUM_TAPS-1-k])`.
    - For k=K-1: `acc += active[K-1]*x[K-1]` (center tap).
    - After k=K-1, go to OUT.
  - OUT: `dout_vld=1` and `dout` is held stable. When `dout_rdy=1`, go to IDLE.
- **Widths:**
  - Pre-add is `WIDTH_IN+1` bits.
  - Product is `WIDTH_IN+1+WIDTH_COEF` bits.
  - Accumulator is `WIDTH_IN+1+WIDTH_COEF+$clog2(K)` bits; it never wraps.
- **Rounding:** round half up, i.e. `(acc + 2^(SHIFT-1)) >>> SHIFT`, computed on the way into OUT and registered into `dout`.
- **Narrowing to `WIDTH_OUT`:** behaviour is selected by the configuration macro (see Configuration).
- **Dropped samples:** `din_vld` while `in_rdy=0` drops the sample, leaves the delay line unchanged, and sets `ovf`. `ovf` is cleared only by reset.
- **Coefficient write on an accept cycle:** if `coef_we` and an accept occur in the same cycle, the copy into `active` uses the shadow contents from before the write; the new value takes effect on the next accept.

## Timing
- **Reset values:** `dout=0`, `dout_vld=0`, `ovf=0`, `in_rdy=0` while `rst_n=0`; FSM in IDLE; delay line and accumulator zero. `in_rdy=1` in the first cycle after reset is released.
- **Latency:** accept at edge E0; MAC runs for cycles 1..K; `dout_vld=1` from cycle K+1 onward. With defaults, K+1 = 9 cycles.
- **Handshake:** `dout` transfers on a cycle with `dout_vld & dout_rdy`. `in_rdy=1` in the cycle after that transfer.
- **Minimum input spacing:** K+2 cycles when `dout_rdy` is held high. At CIC rates ≥ K+2 nothing is dropped.
- **Backpressure:** while `dout_rdy=0`, `dout` and `dout_vld` hold and `in_rdy=0`; any arriving input is dropped and `ovf` is set.
- **Reset mid-MAC or mid-OUT:** the FSM returns to IDLE, the pending output is discarded, and `dout_vld` drops the cycle after reset is sampled.

## Configuration
- `CIC_COMP_FIR_SAT_EN` defined: the rounded value is saturated to `[-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]`.
- `CIC_COMP_FIR_SAT_EN` undefined: the rounded value is truncated to its low `WIDTH_OUT` bits (two's-complement wrap).

## Test plan
- **Impulse response:** after reset, send `din=2^20` followed by 14 samples of `din=0`, with `dout_rdy=1` and spacing 10. Outputs 1..7 are 0, output 8 is 1, and the remaining outputs are 0.
- **Rounding:** hold `din=3*2^19` for 8 samples; the 8th output is 2. Repeat with `din=-3*2^19`; the 8th output is -1.
- **Saturation:** hold `din=2^35-1` for 8 samples. With `CIC_COMP_FIR_SAT_EN`, the 8th output is 32767; without it, the 8th output is -32768.
- **Coefficient load:** write `coef[0..7]=4096`, then send a DC input `din=2^24` for 16 samples. From the 16th output onward `dout=15`. Check separately that a write issued on an accept cycle is not applied until the next accept.
- **Backpressure and drop:** drive `dout_rdy=0` for 20 cycles while `dout_vld=1`, with `din_vld` pulsed once during that window. `dout` stays stable, `in_rdy=0`, and `ovf` rises and stays 1. After `dout_rdy=1`, one transfer occurs and `in_rdy=1` the next cycle.
- **Reset mid-MAC:** assert `rst_n=0` at cycle 4 after an accept. `dout_vld` never rises, and all outputs hold their reset values until new inputs arrive.

Source files
------------

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - symmetric CIC droop-compensation FIR, single shared MAC
// Optional feature macro: CIC_COMP_FIR_SAT_EN (saturate instead of wrap when narrowing)
module cic_comp_fir #(
  parameter int WIDTH_IN   = 36,
  parameter int WIDTH_COEF = 18,
  parameter int NUM_TAPS   = 15,
  parameter int WIDTH_OUT  = 16,
  parameter int SHIFT      = WIDTH_COEF - 2 + WIDTH_IN - WIDTH_OUT,
  localparam int K         = (NUM_TAPS + 1) / 2,
  localparam int AW        = (K > 1) ? $clog2(K) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [WIDTH_IN-1:0]   din,
  input  logic                         din_vld,
  output logic                         in_rdy,
  input  logic                         coef_we,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [WIDTH_COEF-1:0] coef_data,
  output logic signed [WIDTH_OUT-1:0]  dout,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic                         ovf
);

  localparam int TW     = $clog2(NUM_TAPS);
  localparam int PW     = WIDTH_IN + 1;
  localparam int MW     = PW + WIDTH_COEF;
  localparam int ACC_W  = MW + AW;
  localparam int RW     = ACC_W + 1;

  localparam logic signed [WIDTH_COEF-1:0] IMPULSE = {2'b01, {(WIDTH_COEF-2){1'b0}}};
  localparam logic signed [RW-1:0] ROUND_C = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  if ((NUM_TAPS % 2) == 0 || NUM_TAPS < 3) begin : g_bad_taps
    $error("cic_comp_fir: NUM_TAPS must be odd and >= 3");
  end
  if (SHIFT < 1 || SHIFT >= RW || WIDTH_OUT > RW) begin : g_bad_shift
    $error("cic_comp_fir: SHIFT/WIDTH_OUT out of range for accumulator width");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                         state_q, state_d;
  logic [AW-1:0]                  k_q, k_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [WIDTH_OUT-1:0]    dout_q, dout_d;
  logic                           ovf_q;
  logic signed [WIDTH_IN-1:0]     x_q [NUM_TAPS];
  logic signed [WIDTH_COEF-1:0]   shadow_q [K];
  logic signed [WIDTH_COEF-1:0]   active_q [K];

  logic                           accept;
  logic                           drop;
  logic                           last_k;
  logic                           coef_addr_ok;
  logic [TW-1:0]                  mirror_idx;
  logic signed [WIDTH_IN-1:0]     tap_a, tap_b;
  logic signed [PW-1:0]           pre_a, pre_b, pre_sum;
  logic signed [WIDTH_COEF-1:0]   coef_k;
  logic signed [MW-1:0]           prod;
  logic signed [ACC_W-1:0]        acc_sum;
  logic signed [RW-1:0]           rnd;
  logic signed [RW-1:0]           shifted;
  logic signed [WIDTH_OUT-1:0]    narrow;

  // The only way in_rdy can be high is IDLE out of reset; gating with rst_n keeps it low in reset.
  assign in_rdy       = rst_n & (state_q == S_IDLE);
  assign accept       = din_vld & in_rdy;
  assign drop         = din_vld & ~in_rdy;
  assign dout_vld     = (state_q == S_OUT);
  assign dout         = dout_q;
  assign ovf          = ovf_q;
  assign last_k       = (k_q == AW'(K - 1));
  assign coef_addr_ok = ({1'b0, coef_addr} < (AW + 1)'(K));

  // Folded tap pair: x[k] + x[N-1-k]; the center tap has no partner so its mirror is masked.
  assign mirror_idx = TW'(NUM_TAPS - 1) - TW'(k_q);
  assign tap_a      = x_q[TW'(k_q)];
  assign tap_b      = x_q[mirror_idx];
  assign pre_a      = {tap_a[WIDTH_IN-1], tap_a};
  assign pre_b      = last_k ? '0 : {tap_b[WIDTH_IN-1], tap_b};
  assign pre_sum    = pre_a + pre_b;
  assign coef_k     = active_q[k_q];
  assign prod       = MW'(pre_sum) * MW'(coef_k);
  assign acc_sum    = acc_q + ACC_W'(prod);

  // Round half up on the final accumulator value, then arithmetic shift down.
  assign rnd        = RW'(acc_sum) + ROUND_C;
  assign shifted    = rnd >>> SHIFT;

`ifdef CIC_COMP_FIR_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  // Clamp the rounded value into the signed output range.
  always_comb begin
    narrow = shifted[WIDTH_OUT-1:0];
    if (shifted > SAT_MAX) begin
      narrow = SAT_MAX[WIDTH_OUT-1:0];
    end else if (shifted < SAT_MIN) begin
      narrow = SAT_MIN[WIDTH_OUT-1:0];
    end
  end
`else
  logic unused_hi;

  // Two's-complement wrap: keep only the low output bits.
  always_comb begin
    narrow = shifted[WIDTH_OUT-1:0];
  end
  assign unused_hi = ^shifted[RW-1:WIDTH_OUT];
`endif

  // Next-state, tap counter, accumulator and output-register selection.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + AW'(1);
        if (last_k) begin
          k_d     = '0;
          dout_d  = narrow;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (dout_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Delay line: newest sample enters at x[0] only on an accepted input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else if (accept) begin
      x_q[0] <= din;
      for (int i = 1; i < NUM_TAPS; i++) begin
        x_q[i] <= x_q[i-1];
      end
    end
  end

  // Coefficient banks: shadow is written any time, active snapshots shadow's pre-write contents on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        shadow_q[i] <= (i == K - 1) ? IMPULSE : '0;
        active_q[i] <= (i == K - 1) ? IMPULSE : '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < K; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (coef_we && coef_addr_ok) begin
        shadow_q[coef_addr] <= coef_data;
      end
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - scoreboard bench for cic_comp_fir with directed vectors
module tb_cic_comp_fir;

  logic               clk;
  logic               rst_n;
  logic signed [35:0] din;
  logic               din_vld;
  logic               in_rdy;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic signed [15:0] dout;
  logic               dout_vld;
  logic               dout_rdy;
  logic               ovf;

  int errors = 0;
  int checks = 0;
  int out_idx = 0;
  logic signed [15:0] exp_q [$];

`ifdef CIC_COMP_FIR_SAT_EN
  localparam int EXP_SAT = 32767;
`else
  localparam int EXP_SAT = -32768;
`endif

  cic_comp_fir dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .in_rdy    (in_rdy),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every transfer pops one expected value.
  always @(negedge clk) begin
    if (rst_n && dout_vld && dout_rdy) begin
      checks++;
      out_idx++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output #%0d: got %0d, required no output", out_idx, dout);
      end else begin
        logic signed [15:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout #%0d: got %0d, required %0d", out_idx, dout, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    din_vld = 1'b0;
    coef_we = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    out_idx = 0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic signed [17:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input logic signed [35:0] d, input int e, input bit push,
                      input bit we, input logic [2:0] a, input logic signed [17:0] cd);
    int n;
    n = 0;
    while (!in_rdy && n < 100) begin
      tick();
      n++;
    end
    check("send_in_rdy_timeout", longint'(in_rdy), 1);
    din     = d;
    din_vld = 1'b1;
    coef_we = we;
    coef_addr = a;
    coef_data = cd;
    if (push) exp_q.push_back(16'(e));
    tick();
    din_vld = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_rdy) && n < 300) begin
      tick();
      n++;
    end
    check("drain_pending", longint'(exp_q.size()), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_vld   = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    dout_rdy  = 1'b1;

    // Reset state
    tick();
    tick();
    check("reset_dout", dout, 0);
    check("reset_dout_vld", dout_vld, 0);
    check("reset_ovf", ovf, 0);
    check("reset_in_rdy", in_rdy, 0);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_rdy", in_rdy, 1);
    tick();

    // Impulse response through default center-tap coefficient
    for (int i = 0; i < 15; i++) begin
      send((i == 0) ? 36'sd1048576 : 36'sd0, (i == 7) ? 1 : 0, 1'b1, 1'b0, 3'd0, 18'sd0);
    end
    drain();

    // Rounding half up, positive then negative
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(36'sd1572864, (i == 7) ? 2 : 0, 1'b1, 1'b0, 3'd0, 18'sd0);
    end
    drain();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(-36'sd1572864, (i == 7) ? -1 : 0, 1'b1, 1'b0, 3'd0, 18'sd0);
    end
    drain();

    // Full-scale input: saturate or wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(36'sh7_FFFF_FFFF, (i == 7) ? EXP_SAT : 0, 1'b1, 1'b0, 3'd0, 18'sd0);
    end
    drain();

    // Flat coefficient load with DC input: output n = min(n, 15)
    do_reset();
    for (int k = 0; k < 8; k++) begin
      write_coef(3'(k), 18'sd4096);
    end
    for (int n = 1; n <= 16; n++) begin
      send(36'sd16777216, (n < 15) ? n : 15, 1'b1, 1'b0, 3'd0, 18'sd0);
    end
    drain();

    // Coefficient write coinciding with an accept takes effect one sample later
    do_reset();
    send(36'sd1048576, 0, 1'b1, 1'b1, 3'd0, 18'sd65536);
    send(36'sd1048576, 1, 1'b1, 1'b0, 3'd0, 18'sd0);
    drain();

    // Backpressure with one dropped sample
    do_reset();
    write_coef(3'd0, 18'sd65536);
    write_coef(3'd1, 18'sd65536);
    dout_rdy = 1'b0;
    send(36'sd1048576, 1, 1'b1, 1'b0, 3'd0, 18'sd0);
    begin
      int n;
      n = 0;
      while (!dout_vld && n < 50) begin
        tick();
        n++;
      end
    end
    check("bp_dout_vld_rise", dout_vld, 1);
    for (int c = 0; c < 20; c++) begin
      check("bp_dout_hold", dout, 1);
      check("bp_dout_vld_hold", dout_vld, 1);
      check("bp_in_rdy_low", in_rdy, 0);
      check("bp_ovf", ovf, (c > 5) ? 1 : 0);
      if (c == 5) begin
        din     = 36'sd5242880;
        din_vld = 1'b1;
      end
      tick();
      din_vld = 1'b0;
    end
    dout_rdy = 1'b1;
    tick();
    check("bp_in_rdy_after_xfer", in_rdy, 1);
    check("bp_dout_vld_after_xfer", dout_vld, 0);
    send(36'sd0, 1, 1'b1, 1'b0, 3'd0, 18'sd0);
    drain();
    check("bp_ovf_sticky", ovf, 1);

    // Reset in the middle of MAC discards the pending output and the delay line
    do_reset();
    send(36'sd1048576, 0, 1'b0, 1'b0, 3'd0, 18'sd0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("rm_dout_vld", dout_vld, 0);
      check("rm_dout", dout, 0);
      check("rm_ovf", ovf, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      send(36'sd1048576, (i == 7) ? 1 : 0, 1'b1, 1'b0, 3'd0, 18'sd0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
